serial_alu_multi: RTL and testbench
===================================

# serial_alu_multi

Parametrised serial ALU, successor to the fixed 8-bit two-operand serial DUT. It receives framed serial words on `din` under `enable_n` and accumulates 2..`MAX_OPS` operands. A control word carries the opcode, after which the block folds the operands with that operation. It then serialises back a status word and a double-width result on `dout` with `dout_valid`. The block sits behind the same single-bit serial link used by the existing ALU bench.

## Interface
- `DATA_W`, 8, operand/status width; must be ≥ 8.
- `MAX_OPS`, 4, maximum operands per frame; must be ≥ 2.
- `clk`  input  1  clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `enable_n`  input  1  active-low; `din` is valid while low.
- `din`  input  1  serial input, MSB first.
- `dout`  output  1  serial output, MSB first.
- `dout_valid`  output  1  high while a response is being shifted out.

## Operation
- **Word format**: `DATA_W+2` bits, sent in this order: payload type (1 = control, 0 = data), `DATA_W` data bits MSB first, then parity.
  - Parity is the XOR of the type bit and all data bits (even parity over the whole word).
- **Receive**:
  - One bit is sampled per posedge while `enable_n` = 0.
  - `enable_n` = 1 resets the bit counter. A partial word is discarded; already stored operands are kept.
- **Data word**: stored as the next operand.
  - A data word that would be operand `MAX_OPS+1` sets the count-error flag and is dropped.
- **Parity mismatch** on any word of the frame sets the parity-error flag. A data word with bad parity is still stored.
- **Control word**: the opcode is data bits [7:0]; upper bits are ignored.
  - CMD_AND 8'h01, CMD_OR 8'h02, CMD_XOR 8'h03, CMD_ADD 8'h10, CMD_SUB 8'h11.
  - Any other code is invalid.
  - Fewer than 2 stored operands sets the count-error flag.
- **Status word** bits, OR-ed together:
  - bit `DATA_W-1`: invalid command.
  - bit `DATA_W-2`: parity error.
  - bit `DATA_W-3`: count error.
  - All bits 0 means no error.
- **Arithmetic**:
  - Operands are zero-extended to `RES_W = 2*DATA_W`.
  - AND/OR/XOR/ADD fold left to right over all operands.
  - SUB computes op0 − op1 − … − opN.
  - All results are taken modulo 2^RES_W; there is no overflow flag.
  - If any status bit is set, the result is 0.
- **State machine**:
  - RX: collecting words. A control word moves to CALC, or directly to TX on error.
  - CALC: one operand folded per cycle, for N cycles, where N = number of stored operands.
  - TX: transmits three words back to back: status, result[RES_W-1:DATA_W], result[DATA_W-1:0].
    - Each word uses the same format, with type 0 and correct parity.
  - TX then returns to RX with operand count and flags cleared.
- While in CALC/TX, `din` and `enable_n` are ignored; bits sent in that window are lost.

## Timing
- **Reset**: with `rst` = 1 at posedge, the next cycle has:
  - state RX, `dout` = 0, `dout_valid` = 0;
  - operand count 0, flags 0, bit counter 0.
  - This applies in every state, including mid-CALC and mid-TX.
- **Input sampling**: bits are sampled on posedge; the bench drives on negedge.
- **Latency, good frame**: let the last control bit be sampled at edge k. `dout_valid` rises after edge k+N+1 with the first status bit on `dout`.
- **Latency, error frame**: `dout_valid` rises after edge k+1.
- **Output hold**: `dout_valid` stays high for exactly `3*(DATA_W+2)` cycles; one bit per cycle.
- **Idle output**: `dout` = 0 whenever `dout_valid` = 0.
- **Next frame**: the first bit can be accepted the cycle after `dout_valid` falls.

## Configuration
- `SERIAL_ALU_MUL_EN` defined:
  - adds CMD_MUL 8'h20, the product of all operands modulo 2^RES_W;
  - uses one multiply per CALC cycle, so latency is unchanged.
- `SERIAL_ALU_MUL_EN` undefined: 8'h20 is an invalid command (status bit `DATA_W-1`).

## Structure
- Package `serial_alu_pkg` holds:
  - `operation_t` opcode enum;
  - `payload_type_t` enum;
  - status bit-position constants;
  - the `calc_parity` function, shared with the bench.
- Sub-module `serial_alu_tx`: loads three words, shifts `3*(DATA_W+2)` bits, and drives `dout` and `dout_valid`.
- Receiver, operand buffer, FSM and fold ALU live in `serial_alu_multi`.

## Test plan
All scenarios use `DATA_W`=8 and `MAX_OPS`=4.
- ADD with 8'hFF, 8'hFF → status 8'h00, result 16'h01FE; `dout_valid` rises 3 edges after the last control bit.
- AND with 8'hF0, 8'h3C, 8'hFF → status 8'h00, result 16'h0030; latency 4 edges; `dout_valid` high for 30 cycles.
- SUB with 8'h05, 8'h07 → 16'hFFFE. Opcode 8'h55 → status 8'h80, result 0, latency 1 edge.
- Parity bit inverted on operand 2 → status 8'h40. Five data words, or a single data word, → status 8'h20. Each response has correct parity on all three words.
- `enable_n` raised after 4 bits of operand 1, then a full frame ADD 8'h01, 8'h02 → result 16'h0003, with no stale bits.
- `rst` pulsed mid-TX → `dout_valid` = 0 the next cycle; the following frame completes normally. MUL 8'h10, 8'h10 → 16'h0100 with the macro, status 8'h80 without.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types and helpers for the multi-operand serial ALU.
// Opcode encodings, payload type, FSM states, status bit offsets and word parity.
package serial_alu_pkg;

  typedef enum logic [7:0] {
    CMD_AND = 8'h01,
    CMD_OR  = 8'h02,
    CMD_XOR = 8'h03,
    CMD_ADD = 8'h10,
    CMD_SUB = 8'h11,
    CMD_MUL = 8'h20
  } operation_t;

  typedef enum logic {
    PT_DATA = 1'b0,
    PT_CTRL = 1'b1
  } payload_type_t;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_CALC = 2'd1,
    ST_TX   = 2'd2
  } alu_state_t;

  // Status bit positions, counted down from the top of the status word.
  localparam int STATUS_INVALID_OFS = 1;
  localparam int STATUS_PARITY_OFS  = 2;
  localparam int STATUS_COUNT_OFS   = 3;

  localparam int PARITY_MAX_W = 64;

  // Even parity over type bit and data; callers zero-extend data.
  function automatic logic calc_parity(input logic type_bit,
                                       input logic [PARITY_MAX_W-1:0] data);
    return type_bit ^ (^data);
  endfunction

endpackage

// File: rtl/serial_alu_tx.sv
// Response serialiser: frames status, result-high and result-low words and
// shifts them MSB first on dout while dout_valid is high.
module serial_alu_tx
  import serial_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     status,
  input  logic [2*DATA_W-1:0]   result,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  last
);

  localparam int WORD_W = DATA_W + 2;
  localparam int TOTAL  = 3 * WORD_W;
  localparam int CW     = $clog2(TOTAL + 1);

  logic [TOTAL-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             valid;

  function automatic logic [WORD_W-1:0] frame_word(input logic [DATA_W-1:0] d);
    return {PT_DATA, d, calc_parity(PT_DATA, PARITY_MAX_W'(d))};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      sr    <= {frame_word(status),
                frame_word(result[2*DATA_W-1:DATA_W]),
                frame_word(result[DATA_W-1:0])};
      cnt   <= CW'(TOTAL);
      valid <= 1'b1;
    end else if (valid) begin
      sr  <= sr << 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) valid <= 1'b0;
    end
  end

  assign dout       = valid & sr[TOTAL-1];
  assign dout_valid = valid;
  assign last       = valid && (cnt == CW'(1));

endmodule

// File: rtl/serial_alu_multi.sv
// Multi-operand serial ALU: receiver, operand buffer, FSM and fold ALU.
// Define SERIAL_ALU_MUL_EN to add the multiply command (8'h20).
module serial_alu_multi
  import serial_alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_OPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_n,
  input  logic       din,
  output logic       dout,
  output logic       dout_valid,
  output logic [1:0] dbg_state
);

  localparam int WORD_W = DATA_W + 2;
  localparam int RES_W  = 2 * DATA_W;
  localparam int BCW    = $clog2(WORD_W);
  localparam int OCW    = $clog2(MAX_OPS + 1);
  localparam int IW     = $clog2(MAX_OPS);
  localparam logic [OCW-1:0] MAX_CNT = OCW'(MAX_OPS);

  // Handshake: none on the link. din is sampled every posedge while enable_n
  // is low in RX; the response is valid on dout for every cycle dout_valid is high.

  alu_state_t state, state_d;

  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-2:0] rx_sr;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic              w_type;
  logic [DATA_W-1:0] w_data;
  logic              par_bad;

  logic [DATA_W-1:0] ops [MAX_OPS];
  logic [OCW-1:0]    op_cnt;
  logic              par_err;
  logic              cnt_err;
  logic [7:0]        opcode_q;
  logic              op_valid;
  logic [DATA_W-1:0] status, status_next;
  logic              ctrl_err;

  logic [IW-1:0]     calc_idx;
  logic              calc_last;
  logic [RES_W-1:0]  acc, operand, fold_val;

  logic              tx_start, tx_launched, tx_last;

  assign word      = {rx_sr, din};
  assign word_done = (state == ST_RX) && !enable_n && (bit_cnt == BCW'(WORD_W - 1));
  assign w_type    = word[WORD_W-1];
  assign w_data    = word[WORD_W-2:1];
  assign par_bad   = calc_parity(w_type, PARITY_MAX_W'(w_data)) != word[0];

  always_comb begin
    op_valid = 1'b0;
    case (w_data[7:0])
      CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB: op_valid = 1'b1;
`ifdef SERIAL_ALU_MUL_EN
      CMD_MUL: op_valid = 1'b1;
`endif
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    status_next = '0;
    status_next[DATA_W-STATUS_INVALID_OFS] = !op_valid;
    status_next[DATA_W-STATUS_PARITY_OFS]  = par_err | par_bad;
    status_next[DATA_W-STATUS_COUNT_OFS]   = cnt_err | (op_cnt < OCW'(2));
  end

  assign ctrl_err  = |status_next;
  assign calc_last = OCW'(calc_idx) == (op_cnt - OCW'(1));

  // Operand 0 seeds the accumulator; later operands fold into it.
  always_comb begin
    operand  = RES_W'(ops[calc_idx]);
    fold_val = operand;
    if (calc_idx != '0) begin
      case (opcode_q)
        CMD_AND: fold_val = acc & operand;
        CMD_OR:  fold_val = acc | operand;
        CMD_XOR: fold_val = acc ^ operand;
        CMD_ADD: fold_val = acc + operand;
        CMD_SUB: fold_val = acc - operand;
`ifdef SERIAL_ALU_MUL_EN
        CMD_MUL: fold_val = acc * operand;
`endif
        default: fold_val = acc;
      endcase
    end
  end

  always_comb begin
    state_d  = state;
    tx_start = 1'b0;
    case (state)
      ST_RX: begin
        if (word_done && (w_type == PT_CTRL)) state_d = ctrl_err ? ST_TX : ST_CALC;
      end
      ST_CALC: begin
        if (calc_last) state_d = ST_TX;
      end
      ST_TX: begin
        tx_start = !tx_launched;
        if (tx_last) state_d = ST_RX;
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RX;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      op_cnt      <= '0;
      par_err     <= 1'b0;
      cnt_err     <= 1'b0;
      opcode_q    <= '0;
      status      <= '0;
      calc_idx    <= '0;
      acc         <= '0;
      tx_launched <= 1'b0;
    end else begin
      case (state)
        ST_RX: begin
          if (enable_n) begin
            bit_cnt <= '0;
          end else if (word_done) begin
            bit_cnt <= '0;
            if (w_type == PT_DATA) begin
              par_err <= par_err | par_bad;
              if (op_cnt < MAX_CNT) op_cnt  <= op_cnt + OCW'(1);
              else                  cnt_err <= 1'b1;
            end else begin
              opcode_q <= w_data[7:0];
              status   <= status_next;
              calc_idx <= '0;
              acc      <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
            rx_sr   <= {rx_sr[WORD_W-3:0], din};
          end
        end
        ST_CALC: begin
          acc      <= fold_val;
          calc_idx <= calc_idx + IW'(1);
        end
        ST_TX: begin
          if (tx_start) tx_launched <= 1'b1;
          if (tx_last) begin
            tx_launched <= 1'b0;
            op_cnt      <= '0;
            par_err     <= 1'b0;
            cnt_err     <= 1'b0;
            status      <= '0;
            bit_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand storage carries no reset; op_cnt alone says which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && word_done && (w_type == PT_DATA) && (op_cnt < MAX_CNT))
      ops[op_cnt[IW-1:0]] <= w_data;
  end

  serial_alu_tx #(.DATA_W(DATA_W)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (tx_start),
    .status     (status),
    .result     (acc),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last       (tx_last)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_serial_alu_multi.sv
// Randomised scoreboard bench for serial_alu_multi (DATA_W=8, MAX_OPS=4).
module tb_serial_alu_multi;

  localparam int DATA_W    = 8;
  localparam int MAX_OPS   = 4;
  localparam int WORD_W    = DATA_W + 2;
  localparam int RESP_BITS = 3 * WORD_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_n = 1'b1;
  logic din = 1'b0;
  logic dout, dout_valid;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  serial_alu_multi #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] exp_q[$];
  int k_q[$];
  int lat_q[$];
  bit mon_en = 1'b0;
  bit abort  = 1'b0;
  logic [7:0] fops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] frame_word(input logic t, input logic [7:0] d, input bit bad);
    logic p;
    p = (^{t, d}) ^ bad;
    return {t, d, p};
  endfunction

  function automatic bit op_known(input logic [7:0] c);
`ifdef SERIAL_ALU_MUL_EN
    if (c == 8'h20) return 1'b1;
`endif
    return (c == 8'h01) || (c == 8'h02) || (c == 8'h03) || (c == 8'h10) || (c == 8'h11);
  endfunction

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable_n = 1'b1;
      din = 1'b0;
    end
  endtask

  task automatic send_word(input logic t, input logic [7:0] d, input bit bad, output int k);
    logic [WORD_W-1:0] w;
    w = frame_word(t, d, bad);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      @(negedge clk);
      enable_n = 1'b0;
      din = w[i];
    end
    k = cyc + 1;
  endtask

  // Sends fops as data words then opc as control; bad_idx selects a word with flipped parity.
  task automatic run_frame(input logic [7:0] opc, input int bad_idx, input bit push);
    int k, n, lat;
    bit inv, perr, cerr;
    logic [7:0] st;
    logic [15:0] r, x;
    for (int i = 0; i < fops.size(); i++) begin
      send_word(1'b0, fops[i], bad_idx == i, k);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    n    = (fops.size() > MAX_OPS) ? MAX_OPS : fops.size();
    perr = bad_idx >= 0;
    cerr = (fops.size() < 2) || (fops.size() > MAX_OPS);
    inv  = !op_known(opc);
    st   = {inv, perr, cerr, 5'b0};
    r    = 16'h0;
    if (st == 8'h00) begin
      r = {8'h00, fops[0]};
      for (int i = 1; i < n; i++) begin
        x = {8'h00, fops[i]};
        case (opc)
          8'h01: r = r & x;
          8'h02: r = r | x;
          8'h03: r = r ^ x;
          8'h10: r = r + x;
          8'h11: r = r - x;
          8'h20: r = r * x;
          default: r = 16'h0;
        endcase
      end
    end
    lat = (st == 8'h00) ? n + 1 : 1;
    send_word(1'b1, opc, bad_idx == fops.size(), k);
    if (push) begin
      exp_q.push_back(frame_word(1'b0, st, 1'b0));
      exp_q.push_back(frame_word(1'b0, r[15:8], 1'b0));
      exp_q.push_back(frame_word(1'b0, r[7:0], 1'b0));
      k_q.push_back(k);
      lat_q.push_back(lat);
    end
    idle(1);
    if (push) begin
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
      if (exp_q.size() != 0) begin
        check("resp_timeout_words_left", exp_q.size(), 0);
        exp_q.delete();
        k_q.delete();
        lat_q.delete();
      end
    end
  endtask

  // scoreboard monitor
  int run_len = 0;
  int nbits = 0;
  bit prev_valid = 1'b0;
  logic [WORD_W-1:0] cur = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid === 1'b1) begin
        if (!prev_valid && !abort) begin
          check("resp_expected", lat_q.size() != 0, 1);
          if (lat_q.size() != 0) begin
            int k, lat;
            k = k_q.pop_front();
            lat = lat_q.pop_front();
            check("latency", cyc - k, lat);
          end
        end
        run_len++;
        cur = {cur[WORD_W-2:0], dout};
        nbits++;
        if (nbits == WORD_W) begin
          nbits = 0;
          if (!abort) begin
            logic [WORD_W-1:0] e;
            check("resp_word_available", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("resp_word", cur, e);
            end
          end
        end
      end else begin
        check("idle_dout_zero", dout, 0);
        if (prev_valid && !abort) check("valid_run_len", run_len, RESP_BITS);
        run_len = 0;
        nbits = 0;
      end
      prev_valid = (dout_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] opc_tab [8];

  initial begin
    opc_tab = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h55, 8'h00};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_state", dbg_state, 0);
    mon_en = 1'b1;
    idle(2);

    fops = {8'hFF, 8'hFF};             run_frame(8'h10, -1, 1);
    fops = {8'hF0, 8'h3C, 8'hFF};      run_frame(8'h01, -1, 1);
    fops = {8'h05, 8'h07};             run_frame(8'h11, -1, 1);
    fops = {8'h12, 8'h34};             run_frame(8'h55, -1, 1);
    fops = {8'h11, 8'h22, 8'h33};      run_frame(8'h02, 1, 1);
    fops = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; run_frame(8'h10, -1, 1);
    fops = {8'h09};                    run_frame(8'h10, -1, 1);
    fops = {8'hA5, 8'h0F, 8'h3C, 8'hFF}; run_frame(8'h03, -1, 1);
    fops = {8'h10, 8'h10};             run_frame(8'h20, -1, 1);

    // partial word discarded by enable_n going high
    begin
      logic [WORD_W-1:0] pw;
      pw = frame_word(1'b0, 8'hC3, 1'b0);
      for (int i = WORD_W - 1; i >= WORD_W - 4; i--) begin
        @(negedge clk);
        enable_n = 1'b0;
        din = pw[i];
      end
      idle(1);
    end
    fops = {8'h01, 8'h02};             run_frame(8'h10, -1, 1);

    // reset pulsed mid-transmit
    abort = 1'b1;
    fops = {8'h01, 8'h02};             run_frame(8'h10, -1, 0);
    for (int t = 0; t < 50 && dout_valid !== 1'b1; t++) @(negedge clk);
    check("rst_tx_started", dout_valid, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx_valid", dout_valid, 0);
    check("rst_mid_tx_dout", dout, 0);
    check("rst_mid_tx_state", dbg_state, 0);
    @(negedge clk);
    abort = 1'b0;
    fops = {8'h40, 8'h03};             run_frame(8'h11, -1, 1);

    // randomised frames
    for (int f = 0; f < 24; f++) begin
      int n, bad;
      logic [7:0] opc;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : $urandom_range(2, 4);
      fops.delete();
      for (int i = 0; i < n; i++) fops.push_back(8'($urandom_range(0, 255)));
      opc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : opc_tab[$urandom_range(0, 7)];
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : -1;
      run_frame(opc, bad, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(4);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_lat_q_empty", lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
